// File: rtl/instr_fetch_unit_pkg.sv
// Types and constants shared by the instruction fetch unit and the decode logic
// that consumes its Op/funct3/funct7 fields.
package instr_fetch_unit_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StWait = 2'd2,
    StHold = 2'd3
  } ifu_state_e;

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpOpImm  = 7'b0010011;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpOp     = 7'b0110011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpJal    = 7'b1101111;

  // addi x0, x0, 0
  localparam logic [31:0] NopInstr = {12'h000, 5'd0, 3'b000, 5'd0, OpOpImm};

  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_pc_next_sel.sv
// Next-fetch-address selection: sequential PC+4 or a word-aligned redirect target.
module instr_fetch_unit_pc_next_sel
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic            pc_src_i,
  input  logic [XLEN-1:0] pc_target_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic [XLEN-1:0] pc_plus4_o,
  output logic            misalign_o
);

  always_comb begin
    pc_plus4_o = pc_i + XLEN'(4);
    misalign_o = pc_src_i & is_misaligned(pc_target_i[1:0]);
    // Misaligned targets still redirect, with the low bits dropped.
    next_pc_o  = pc_src_i ? {pc_target_i[XLEN-1:2], 2'b00} : pc_plus4_o;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetcher: owns the PC, requests one word at a time
// and holds the fetched instruction until the core accepts it.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned    XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [31:0]     Instr,
  output logic [6:0]      Op,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  input  logic            PCSrc,
  input  logic [XLEN-1:0] PCTarget,
  output logic            misaligned
);

  ifu_state_e      state_q;
  logic            req_valid_q;
  logic [XLEN-1:0] fetch_pc_q;
  logic [31:0]     instr_q;
  logic [XLEN-1:0] pc_q;
  logic            instr_valid_q;
  logic            misaligned_q;

  logic [XLEN-1:0] next_pc;
  logic            misalign;

  instr_fetch_unit_pc_next_sel #(
    .XLEN(XLEN)
  ) u_pc_next_sel (
    .pc_i       (pc_q),
    .pc_src_i   (PCSrc),
    .pc_target_i(PCTarget),
    .next_pc_o  (next_pc),
    .pc_plus4_o (PCPlus4),
    .misalign_o (misalign)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIdle;
      req_valid_q   <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      instr_q       <= NopInstr;
      pc_q          <= RESET_PC;
      instr_valid_q <= 1'b0;
      misaligned_q  <= 1'b0;
    end else begin
      misaligned_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          state_q     <= StReq;
          req_valid_q <= 1'b1;
        end
        StReq: begin
          if (imem_req_ready) begin
            state_q     <= StWait;
            req_valid_q <= 1'b0;
          end
        end
        // Responses are only honoured here; anything arriving in other states is stale.
        StWait: begin
          if (imem_rsp_valid) begin
            instr_q       <= imem_rsp_data;
            pc_q          <= fetch_pc_q;
            instr_valid_q <= 1'b1;
            state_q       <= StHold;
          end
        end
        StHold: begin
          if (instr_valid_q && instr_ready) begin
            fetch_pc_q    <= next_pc;
            misaligned_q  <= misalign;
            instr_valid_q <= 1'b0;
            req_valid_q   <= 1'b1;
            state_q       <= StReq;
          end
        end
        default: begin
          state_q     <= StIdle;
          req_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req_valid = req_valid_q;
  assign imem_addr      = fetch_pc_q;
  assign instr_valid    = instr_valid_q;
  assign Instr          = instr_q;
  assign Op             = instr_q[6:0];
  assign funct3         = instr_q[14:12];
  assign funct7         = instr_q[31:25];
  assign PC             = pc_q;
  assign misaligned     = misaligned_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed vector table, reset-in-flight sequence and a
// randomized run checked against a transaction-level fetch model.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] Instr;
  logic [6:0]  Op;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        PCSrc;
  logic [31:0] PCTarget;
  logic        misaligned;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  localparam logic [31:0] Nop = 32'h0000_0013;

  instr_fetch_unit #(
    .XLEN    (32),
    .RESET_PC(32'h0000_0000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr     (imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .Instr         (Instr),
    .Op            (Op),
    .funct3        (funct3),
    .funct7        (funct7),
    .PC            (PC),
    .PCPlus4       (PCPlus4),
    .PCSrc         (PCSrc),
    .PCTarget      (PCTarget),
    .misaligned    (misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1);
  end

  typedef struct {
    int          stall;
    int          rsp_dly;
    int          hold;
    logic        src;
    logic [31:0] tgt;
    logic [31:0] exp_next;
    logic        exp_mis;
  } vec_t;

  vec_t vecs[8];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, ~a[31:16]} ^ (a * 32'h9E37_79B9);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // One complete fetch transaction starting in the request cycle for addr.
  task automatic do_fetch(input string tag, input logic [31:0] addr, input int stall,
                          input int rsp_dly, input int hold, input logic src,
                          input logic [31:0] tgt, input logic [31:0] exp_next,
                          input logic exp_mis, output int valid_cyc);
    logic [31:0] w;
    logic [31:0] plus4;
    w     = mem_word(addr);
    plus4 = addr + 32'd4;
    chk($sformatf("%s req_valid", tag), 32'(imem_req_valid), 32'd1);
    chk($sformatf("%s req_addr", tag), imem_addr, addr);
    for (int i = 0; i < stall; i++) begin
      imem_req_ready = 1'b0;
      imem_rsp_valid = (i == 0);
      imem_rsp_data  = $urandom;
      step();
      chk($sformatf("%s stall addr", tag), imem_addr, addr);
      chk($sformatf("%s stall instr_valid", tag), 32'(instr_valid), 32'd0);
      chk($sformatf("%s stall misaligned", tag), 32'(misaligned), 32'd0);
    end
    imem_rsp_valid = 1'b0;
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    chk($sformatf("%s req dropped", tag), 32'(imem_req_valid), 32'd0);
    chk($sformatf("%s misaligned clear", tag), 32'(misaligned), 32'd0);
    for (int i = 1; i < rsp_dly; i++) begin
      step();
      chk($sformatf("%s wait instr_valid", tag), 32'(instr_valid), 32'd0);
    end
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = w;
    step();
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = $urandom;
    valid_cyc      = cyc;
    chk($sformatf("%s instr_valid", tag), 32'(instr_valid), 32'd1);
    chk($sformatf("%s Instr", tag), Instr, w);
    chk($sformatf("%s PC", tag), PC, addr);
    chk($sformatf("%s PCPlus4", tag), PCPlus4, plus4);
    chk($sformatf("%s Op", tag), 32'(Op), 32'(w[6:0]));
    chk($sformatf("%s funct3", tag), 32'(funct3), 32'(w[14:12]));
    chk($sformatf("%s funct7", tag), 32'(funct7), 32'(w[31:25]));
    for (int i = 0; i < hold; i++) begin
      imem_rsp_valid = 1'($urandom_range(0, 1));
      imem_rsp_data  = $urandom;
      PCSrc          = 1'($urandom_range(0, 1));
      PCTarget       = $urandom;
      step();
      chk($sformatf("%s hold Instr", tag), Instr, w);
      chk($sformatf("%s hold PC", tag), PC, addr);
      chk($sformatf("%s hold instr_valid", tag), 32'(instr_valid), 32'd1);
      chk($sformatf("%s hold no req", tag), 32'(imem_req_valid), 32'd0);
    end
    imem_rsp_valid = 1'b0;
    instr_ready    = 1'b1;
    PCSrc          = src;
    PCTarget       = tgt;
    step();
    instr_ready = 1'b0;
    PCSrc       = 1'($urandom_range(0, 1));
    PCTarget    = $urandom;
    chk($sformatf("%s misaligned", tag), 32'(misaligned), 32'(exp_mis));
    chk($sformatf("%s instr_valid after accept", tag), 32'(instr_valid), 32'd0);
    chk($sformatf("%s next req_valid", tag), 32'(imem_req_valid), 32'd1);
    chk($sformatf("%s next addr", tag), imem_addr, exp_next);
  endtask

  initial begin
    logic [31:0] cur;
    logic [31:0] model_next;
    logic        model_mis;
    logic        src;
    logic [31:0] tgt;
    int          vcyc;

    rst            = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b0;
    PCSrc          = 1'b0;
    PCTarget       = '0;

    vecs[0] = '{0, 1, 5, 1'b0, 32'h0000_0000, 32'h0000_0004, 1'b0};
    vecs[1] = '{0, 1, 0, 1'b0, 32'h0000_0000, 32'h0000_0008, 1'b0};
    vecs[2] = '{0, 2, 1, 1'b1, 32'h0000_0100, 32'h0000_0100, 1'b0};
    vecs[3] = '{0, 1, 0, 1'b1, 32'h0000_0102, 32'h0000_0100, 1'b1};
    vecs[4] = '{3, 1, 2, 1'b1, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 1'b1};
    vecs[5] = '{1, 3, 0, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[6] = '{0, 1, 0, 1'b1, 32'h0000_0203, 32'h0000_0200, 1'b1};
    vecs[7] = '{2, 1, 1, 1'b0, 32'h0000_0000, 32'h0000_0204, 1'b0};

    step();
    step();
    chk("reset req_valid", 32'(imem_req_valid), 32'd0);
    chk("reset imem_addr", imem_addr, 32'h0);
    chk("reset instr_valid", 32'(instr_valid), 32'd0);
    chk("reset misaligned", 32'(misaligned), 32'd0);
    chk("reset Instr", Instr, Nop);
    chk("reset PC", PC, 32'h0);
    chk("reset PCPlus4", PCPlus4, 32'h4);
    chk("reset Op", 32'(Op), 32'h13);
    chk("reset funct3", 32'(funct3), 32'd0);
    chk("reset funct7", 32'(funct7), 32'd0);

    rst = 1'b1;
    cyc = 0;
    chk("idle req_valid", 32'(imem_req_valid), 32'd0);
    step();

    cur = 32'h0;
    foreach (vecs[i]) begin
      do_fetch($sformatf("vec%0d", i), cur, vecs[i].stall, vecs[i].rsp_dly, vecs[i].hold,
               vecs[i].src, vecs[i].tgt, vecs[i].exp_next, vecs[i].exp_mis, vcyc);
      if (i == 0) chk("first instr_valid cycle", 32'(vcyc), 32'd3);
      cur = vecs[i].exp_next;
    end

    // Reset while a request is outstanding, then the stale response shows up.
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst = 1'b0;
    step();
    chk("rst-wait req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst-wait addr", imem_addr, 32'h0);
    chk("rst-wait Instr", Instr, Nop);
    rst            = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    chk("stale rsp instr_valid", 32'(instr_valid), 32'd0);
    chk("stale rsp Instr", Instr, Nop);
    chk("stale rsp PC", PC, 32'h0);
    do_fetch("post-reset", 32'h0, 1, 2, 0, 1'b0, 32'h0, 32'h4, 1'b0, vcyc);

    // Randomized transactions against the fetch-address model.
    cur = 32'h4;
    for (int n = 0; n < 40; n++) begin
      src = 1'($urandom_range(0, 1));
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(0, 3)))
                                        : $urandom;
      if (src) model_next = tgt & 32'hFFFF_FFFC;
      else     model_next = cur + 32'd4;
      model_mis = src && (tgt % 4 != 0);
      do_fetch($sformatf("rnd%0d", n), cur, $urandom_range(0, 3), $urandom_range(1, 3),
               $urandom_range(0, 3), src, tgt, model_next, model_mis, vcyc);
      cur = model_next;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
